// File: rtl/sobel_magnitude.sv
// sobel_magnitude: saturated L1 gradient magnitude sweep GX/GY RAM -> MAG RAM, with edge count
//   clk, resetn          : clock, async active-low reset
//   Start / Done         : level run request / sticky completion (held until Start low)
//   threshold            : edge threshold, latched when a sweep starts
//   GX_*, GY_*           : synchronous-read source RAM ports (1-cycle latency), same address every cycle
//   MAG_*                : result RAM write port, write k lands 2 cycles after read k
//   edge_count           : pixels with magnitude >= threshold, valid when Done=1
module sobel_magnitude #(
  parameter int width          = 8,
  parameter int GX_depth_bits  = 14,
  parameter int GY_depth_bits  = 14,
  parameter int MAG_depth_bits = 14,
  parameter int NUM_WORDS      = 15876,
  parameter int BINARIZE       = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      Start,
  output logic                      Done,
  input  logic [width-1:0]          threshold,
  output logic                      GX_read_en,
  output logic [GX_depth_bits-1:0]  GX_read_address,
  input  logic [width-1:0]          GX_read_data_out,
  output logic                      GY_read_en,
  output logic [GY_depth_bits-1:0]  GY_read_address,
  input  logic [width-1:0]          GY_read_data_out,
  output logic                      MAG_write_en,
  output logic [MAG_depth_bits-1:0] MAG_write_address,
  output logic [width-1:0]          MAG_write_data_in,
  output logic [MAG_depth_bits:0]   edge_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  localparam logic [GX_depth_bits-1:0]  LAST_RD = GX_depth_bits'(NUM_WORDS - 1);
  localparam logic [MAG_depth_bits-1:0] LAST_WR = MAG_depth_bits'(NUM_WORDS - 1);
  state_t state, state_nx;
  logic [width-1:0] thr, mag, wdata;
  logic [width:0] sum;
  logic [GX_depth_bits-1:0] addr_nx;
  logic [MAG_depth_bits-1:0] a1;
  logic v1, hit, keep, wr_nx, start_run;
  always_comb begin
    sum = {1'b0, GX_read_data_out} + {1'b0, GY_read_data_out};
    mag = sum[width] ? {width{1'b1}} : sum[width-1:0];
    hit = mag >= thr;
    wdata = (BINARIZE != 0) ? {width{hit}} : mag;
    // Start low anywhere returns to Idle: abort in Run/Drain, release in Finish
    state_nx = !Start ? IDLE :
               state == IDLE ? RUN :
               state == RUN ? (GX_read_address == LAST_RD ? DRAIN : RUN) :
               state == DRAIN ? ((MAG_write_en && MAG_write_address == LAST_WR) ? FINISH : DRAIN) :
               FINISH;
    start_run = state == IDLE && Start;
    keep = state_nx == RUN || state_nx == DRAIN;
    wr_nx = v1 && keep;
    addr_nx = (state == RUN && state_nx == RUN) ? GX_read_address + GX_depth_bits'(1) : '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      thr <= '0;
      v1 <= 1'b0;
      a1 <= '0;
      Done <= 1'b0;
      GX_read_en <= 1'b0;
      GY_read_en <= 1'b0;
      GX_read_address <= '0;
      GY_read_address <= '0;
      MAG_write_en <= 1'b0;
      MAG_write_address <= '0;
      MAG_write_data_in <= '0;
      edge_count <= '0;
    end else begin
      state <= state_nx;
      thr <= start_run ? threshold : thr;
      GX_read_en <= state_nx == RUN;
      GY_read_en <= state_nx == RUN;
      GX_read_address <= addr_nx;
      GY_read_address <= GY_depth_bits'(addr_nx);
      v1 <= GX_read_en && keep;
      a1 <= MAG_depth_bits'(GX_read_address);
      MAG_write_en <= wr_nx;
      MAG_write_address <= wr_nx ? a1 : '0;
      MAG_write_data_in <= wr_nx ? wdata : '0;
      edge_count <= start_run ? '0 : (wr_nx && hit) ? edge_count + (MAG_depth_bits + 1)'(1) : edge_count;
      Done <= state_nx == FINISH;
    end
  end
endmodule

// File: tb/tb_sobel_magnitude.sv
// tb_sobel_magnitude: scoreboard bench for sobel_magnitude (linear and binarized instances)
module tb_sobel_magnitude;
  localparam int N = 15876;
  logic clk = 0, resetn = 0, start_a = 0, start_b = 0, sel = 0;
  logic [7:0] threshold = 0, gx_q = 0, gy_q = 0;
  int mode = 0;
  int n_checks = 0, n_fail = 0;
  logic a_done, a_gx_en, a_gy_en, a_wr_en, b_done, b_gx_en, b_gy_en, b_wr_en;
  logic [13:0] a_gx_addr, a_gy_addr, a_wr_addr, b_gx_addr, b_gy_addr, b_wr_addr;
  logic [7:0] a_wr_data, b_wr_data;
  logic [14:0] a_edges, b_edges;
  logic m_done, m_gx_en, m_gy_en, m_wr_en;
  logic [13:0] m_gx_addr, m_gy_addr, m_wr_addr;
  logic [7:0] m_wr_data;
  logic [14:0] m_edges;
  typedef struct {int a; logic [7:0] d;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  sobel_magnitude u_a (
    .clk(clk), .resetn(resetn), .Start(start_a), .Done(a_done), .threshold(threshold),
    .GX_read_en(a_gx_en), .GX_read_address(a_gx_addr), .GX_read_data_out(gx_q),
    .GY_read_en(a_gy_en), .GY_read_address(a_gy_addr), .GY_read_data_out(gy_q),
    .MAG_write_en(a_wr_en), .MAG_write_address(a_wr_addr), .MAG_write_data_in(a_wr_data),
    .edge_count(a_edges));
  sobel_magnitude #(.BINARIZE(1)) u_b (
    .clk(clk), .resetn(resetn), .Start(start_b), .Done(b_done), .threshold(threshold),
    .GX_read_en(b_gx_en), .GX_read_address(b_gx_addr), .GX_read_data_out(gx_q),
    .GY_read_en(b_gy_en), .GY_read_address(b_gy_addr), .GY_read_data_out(gy_q),
    .MAG_write_en(b_wr_en), .MAG_write_address(b_wr_addr), .MAG_write_data_in(b_wr_data),
    .edge_count(b_edges));
  assign m_done = sel ? b_done : a_done;
  assign m_gx_en = sel ? b_gx_en : a_gx_en;
  assign m_gy_en = sel ? b_gy_en : a_gy_en;
  assign m_wr_en = sel ? b_wr_en : a_wr_en;
  assign m_gx_addr = sel ? b_gx_addr : a_gx_addr;
  assign m_gy_addr = sel ? b_gy_addr : a_gy_addr;
  assign m_wr_addr = sel ? b_wr_addr : a_wr_addr;
  assign m_wr_data = sel ? b_wr_data : a_wr_data;
  assign m_edges = sel ? b_edges : a_edges;

  function automatic logic [7:0] gx_fn(int md, int a);
    return md == 0 ? 8'(a % 256) : md == 1 ? 8'd200 : 8'd64;
  endfunction
  function automatic logic [7:0] gy_fn(int md, int a);
    return md == 1 ? 8'd100 : md == 2 ? ((a % 2) != 0 ? 8'd64 : 8'd63) : 8'd0;
  endfunction
  function automatic logic [7:0] exp_fn(int md, int a, logic [7:0] t, logic bin);
    int s;
    s = int'(gx_fn(md, a)) + int'(gy_fn(md, a));
    if (s > 255) s = 255;
    return bin ? ((s >= int'(t)) ? 8'd255 : 8'd0) : 8'(s);
  endfunction

  always @(posedge clk) begin
    if (m_gx_en) gx_q <= gx_fn(mode, int'(m_gx_addr));
    if (m_gy_en) gy_q <= gy_fn(mode, int'(m_gy_addr));
  end

  task automatic run_sweep(input logic s, input int md, input logic [7:0] t, input int edges, input string nm);
    int cyc = 0, writes = 0, next_rd = 0, d1a = 0, d2a = 0;
    bit d1v = 0, d2v = 0, done_seen = 0;
    exp_t e;
    sel = s; mode = md; threshold = t; sb.delete();
    if (s) start_b = 1; else start_a = 1;
    while (!done_seen && cyc < N + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) threshold = t ^ 8'h5A;
      n_checks++;
      if (m_gx_en !== m_gy_en || m_gx_addr !== m_gy_addr) begin
        n_fail++;
        $display("FAIL %s gx_gy_same: gx=%b/%0d gy=%b/%0d", nm, m_gx_en, m_gx_addr, m_gy_en, m_gy_addr);
      end
      if (m_gx_en) begin
        n_checks++;
        if (int'(m_gx_addr) !== next_rd || next_rd >= N) begin
          n_fail++;
          $display("FAIL %s read_addr: got %0d expected %0d (limit %0d)", nm, m_gx_addr, next_rd, N - 1);
        end
        next_rd++;
        e.a = int'(m_gx_addr);
        e.d = exp_fn(md, e.a, t, s);
        sb.push_back(e);
      end
      if (m_wr_en) begin
        writes++;
        n_checks++;
        if (!d2v || int'(m_wr_addr) !== d2a) begin
          n_fail++;
          $display("FAIL %s write_delay: write addr %0d, read 2 cycles before valid=%0b addr=%0d", nm, m_wr_addr, d2v, d2a);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_write: addr %0d data %0d, nothing expected", nm, m_wr_addr, m_wr_data);
        end else begin
          e = sb.pop_front();
          if (int'(m_wr_addr) !== e.a || m_wr_data !== e.d) begin
            n_fail++;
            $display("FAIL %s write_data: got addr %0d data %0d expected addr %0d data %0d", nm, m_wr_addr, m_wr_data, e.a, e.d);
          end
        end
      end
      d2v = d1v; d2a = d1a; d1v = m_gx_en; d1a = int'(m_gx_addr);
      done_seen = m_done;
    end
    n_checks++;
    if (!done_seen || cyc != N + 3) begin
      n_fail++;
      $display("FAIL %s done_latency: done=%0b after %0d cycles expected %0d", nm, done_seen, cyc, N + 3);
    end
    n_checks++;
    if (writes != N || next_rd != N || sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s counts: writes %0d reads %0d pending %0d expected %0d/%0d/0", nm, writes, next_rd, sb.size(), N, N);
    end
    n_checks++;
    if (int'(m_edges) !== edges) begin
      n_fail++;
      $display("FAIL %s edge_count: got %0d expected %0d", nm, m_edges, edges);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({a_done, a_gx_en, a_gy_en, a_wr_en, a_gx_addr, a_gy_addr, a_wr_addr, a_wr_data, a_edges} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %0h expected 0", {a_done, a_gx_en, a_gy_en, a_wr_en, a_gx_addr, a_gy_addr, a_wr_addr, a_wr_data, a_edges});
    end
    n_checks++;
    if ({b_done, b_gx_en, b_wr_en, b_edges} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %0h expected 0", {b_done, b_gx_en, b_wr_en, b_edges});
    end
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    n_checks++;
    if (a_done !== 1'b0 || a_gx_en !== 1'b0 || a_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: done=%b rd=%b wr=%b expected 0", a_done, a_gx_en, a_wr_en);
    end
  endtask

  task automatic test_ramp();
    int bad = 0;
    run_sweep(0, 0, 8'd0, N, "ramp");
    repeat (20) begin
      @(posedge clk); #1;
      if (!a_done || a_gx_en || a_wr_en) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL held_start: %0d cycles with done low or activity, expected 0", bad);
    end
    start_a = 0;
    @(posedge clk); #1;
    n_checks++;
    if (a_done !== 1'b0 || int'(a_edges) !== N) begin
      n_fail++;
      $display("FAIL release: done=%b edges=%0d expected 0/%0d", a_done, a_edges, N);
    end
  endtask

  task automatic test_saturate();
    run_sweep(0, 1, 8'd255, N, "saturate");
    start_a = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_binarize();
    run_sweep(1, 2, 8'd128, N / 2, "binarize");
    start_b = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int bad = 0;
    sel = 0; mode = 0; threshold = 8'd100;
    start_a = 1;
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (a_gx_en !== 1'b1 || a_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_running: rd=%b wr=%b expected 1/1", a_gx_en, a_wr_en);
    end
    start_a = 0;
    @(posedge clk); #1;
    n_checks++;
    if (a_gx_en !== 1'b0 || a_gy_en !== 1'b0 || a_wr_en !== 1'b0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: gx=%b gy=%b wr=%b done=%b expected 0", a_gx_en, a_gy_en, a_wr_en, a_done);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (a_wr_en || a_gx_en) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d active cycles expected 0", bad);
    end
    run_sweep(0, 0, 8'd100, 62 * 156, "restart");
    start_a = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_drain_reset();
    int cyc = 0, bad = 0;
    bit seen = 0;
    sel = 0; mode = 1; threshold = 8'd0;
    start_a = 1;
    while (cyc < N + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (seen && !a_gx_en) break;
      seen |= a_gx_en;
    end
    n_checks++;
    if (!seen || a_gx_en !== 1'b0 || a_done !== 1'b0 || a_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_reached: seen=%0b rd=%b done=%b wr=%b expected 1/0/0/1", seen, a_gx_en, a_done, a_wr_en);
    end
    #2 resetn = 0;
    #1;
    n_checks++;
    if ({a_done, a_gx_en, a_gy_en, a_wr_en, a_gx_addr, a_wr_addr, a_wr_data, a_edges} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %0h expected 0", {a_done, a_gx_en, a_gy_en, a_wr_en, a_gx_addr, a_wr_addr, a_wr_data, a_edges});
    end
    start_a = 0;
    @(posedge clk);
    @(negedge clk) resetn = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (a_wr_en || a_done || a_gx_en) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturate();
    test_binarize();
    test_abort();
    test_drain_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_magnitude.md
Name: sobel_magnitude

Overview:
- Post-processing stage directly downstream of the Sobel convolution engine.
- Sweeps GX_RAM and GY_RAM, computes a saturated L1 gradient magnitude per pixel, optionally binarizes it against a runtime threshold, and writes the result to MAG_RAM.
- Also counts edge pixels (magnitude >= threshold).
- Uses the same level-Start / sticky-Done handshake as the Sobel engine, so the myip wrapper can chain the two.

Parameters:
- width, 8, bits per RAM word (GX, GY, MAG, threshold).
- GX_depth_bits, 14, GX_RAM address width.
- GY_depth_bits, 14, GY_RAM address width.
- MAG_depth_bits, 14, MAG_RAM address width.
- NUM_WORDS, 15876, pixels to process (126x126 valid Sobel outputs), addresses 0..NUM_WORDS-1.
- BINARIZE, 0, 0 = write saturated magnitude; 1 = write 255 if magnitude >= threshold, else 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- Start  in  1  level run request from wrapper; deassertion aborts/clears.
- Done  out  1  high when sweep complete; held until Start low.
- threshold  in  width  edge threshold, sampled on Idle->Run.
- GX_read_en  out  1  GX_RAM read enable.
- GX_read_address  out  GX_depth_bits  GX_RAM address.
- GX_read_data_out  in  width  GX_RAM data, valid 1 cycle after address (synchronous read).
- GY_read_en  out  1  GY_RAM read enable.
- GY_read_address  out  GY_depth_bits  GY_RAM address.
- GY_read_data_out  in  width  GY_RAM data, 1-cycle read latency.
- MAG_write_en  out  1  MAG_RAM write strobe.
- MAG_write_address  out  MAG_depth_bits  MAG_RAM address.
- MAG_write_data_in  out  width  MAG_RAM data.
- edge_count  out  MAG_depth_bits+1  number of pixels with magnitude >= threshold; valid when Done=1.

Behaviour:
- Reset (resetn low, async):
  - State=Idle.
  - All outputs 0: Done, read/write enables, addresses, write data, edge_count.
  - Internal counters and the threshold latch cleared.
- States: Idle, Run, Drain, Finish.
- Idle:
  - Outputs quiescent.
  - If Start=1: latch threshold, clear edge_count, set GX/GY_read_address=0, assert both read_en, go to Run.
- Run:
  - One read per cycle; GX and GY addresses are always equal.
  - Address increments each cycle up to NUM_WORDS-1.
  - After address NUM_WORDS-1 is issued: read_en=0, go to Drain.
- Pipeline:
  - Stage 1: data for address k arrives the cycle after k was presented; a valid-tag register tracks it.
  - Stage 2: registered write. MAG_write_en=1 with MAG_write_address=k appears exactly 2 cycles after read address k was presented.
  - Throughput: 1 pixel/cycle, no bubbles.
- Arithmetic:
  - GX and GY are unsigned (the Sobel stage stores absolute values).
  - sum = GX+GY in width+1 bits.
  - mag = (sum > 2^width-1) ? 2^width-1 : sum[width-1:0].
  - Write data = mag if BINARIZE=0; (mag >= threshold ? all-ones : 0) if BINARIZE=1.
  - edge_count increments in the same cycle as the write when mag >= threshold.
  - threshold=0 counts every pixel.
- Drain: waits until the last write (address NUM_WORDS-1) is issued, then goes to Finish.
- Finish:
  - Entered the cycle after the last write; MAG_write_en=0, Done=1.
  - Stays here while Start=1.
  - When Start=0: Done=0, go to Idle; edge_count keeps its value until the next Start.
- Total latency: Start sampled high to Done high = NUM_WORDS+3 cycles.
- Abort: Start=0 in Run or Drain → next cycle all enables=0, Done=0, state=Idle. In-flight writes are discarded; MAG_RAM contents are undefined.
- Start held high after Done does not restart; a rerun requires Start low for at least 1 cycle.
- threshold changes during Run have no effect, since the latched value is used.
- Async reset mid-operation: immediate return to reset values, with no partial write strobe afterward.
- Address counter never wraps: the last read address is NUM_WORDS-1; there are no reads at NUM_WORDS or higher.

Test Plan:
- GX=i%256, GY=0, BINARIZE=0, threshold=0, Start held → MAG[i]=i%256 for all i; edge_count=15876; Done rises exactly 15879 cycles after Start sampled.
- GX=200, GY=100 everywhere → every MAG word=255 (saturation, not 44); check no write to address 15876.
- BINARIZE=1, threshold=128, GX=64, GY alternating 63/64 → MAG alternates 0/255; edge_count=7938.
- Start dropped 100 cycles into Run → next cycle enables=0, Done=0, state Idle. Restart with Start → full sweep from address 0 and correct edge_count.
- resetn pulsed low mid-Drain → outputs 0 asynchronously, no write strobe after release. Start held high across Done → Done stays 1, no second sweep until Start toggles low.
- Check that write address equals read address delayed by 2 cycles throughout, and GX/GY addresses are identical every cycle.
